// File: rtl/instr_feeder_pkg.sv
// Shared types and constants for the instruction feeder.
// Used by instr_feeder and feeder_ram.
package instr_feeder_pkg;

  localparam int DATA_W = 16;
  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [OP_MSB-OP_LSB:0] op_t;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam op_t OP_MV  = 3'b000;
  localparam op_t OP_MVI = 3'b001;
  localparam op_t OP_ADD = 3'b010;
  localparam op_t OP_SUB = 3'b011;

  function automatic op_t op_of(input word_t w);
    return w[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/feeder_ram.sv
// Program RAM: 2**AW words, synchronous write, two async reads.
// No reset; contents survive a feeder reset.
module feeder_ram
  import instr_feeder_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  word_t         wr_data,
  input  logic [AW-1:0] rd_addr_a,
  output word_t         rd_data_a,
  input  logic [AW-1:0] rd_addr_b,
  output word_t         rd_data_b
);

  word_t mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/instr_feeder.sv
// Issues program words to the bus processor with a Run strobe.
// Optional watchdog enabled by defining INSTR_FEEDER_WDOG_EN.
module instr_feeder
  import instr_feeder_pkg::*;
#(
  parameter int AW       = 4,
  parameter int WDOG_CYC = 15
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          LdEn,
  input  logic [AW-1:0] LdAddr,
  input  logic [15:0]   LdData,
  input  logic          Start,
  input  logic [AW:0]   ProgLen,
  output logic [15:0]   DIN,
  output logic          Run,
  input  logic          Done,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Halted,
  output logic          Fault
);

  if (WDOG_CYC < 1) begin : g_bad_cfg
    $error("WDOG_CYC must be at least 1");
  end

  logic [1:0]    state;
  logic [AW-1:0] pc;
  logic [AW:0]   len;
  op_t           op_q;
  word_t         cur_w;
  word_t         nxt_w;
  logic [AW:0]   step;
  logic [AW:0]   npc;
  logic          idle_like;
  logic          start_ok;
  logic          ram_we;
  logic          wdog_hit;

  assign idle_like = (state == S_IDLE) || (state == S_HALT);
  assign start_ok  = Start && idle_like;
  assign ram_we    = LdEn && idle_like;

  feeder_ram #(.AW(AW)) u_ram (
    .clk       (Clock),
    .we        (ram_we),
    .wr_addr   (LdAddr),
    .wr_data   (LdData),
    .rd_addr_a (pc),
    .rd_data_a (cur_w),
    .rd_addr_b (pc + 1'b1),
    .rd_data_b (nxt_w)
  );

  // mvi consumes its immediate slot too
  assign step = (op_q == OP_MVI) ? (AW+1)'(2) : (AW+1)'(1);
  assign npc  = {1'b0, pc} + step;

`ifdef INSTR_FEEDER_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC + 1);

  logic [WW-1:0] wcnt;
  logic          fault_q;

  assign wdog_hit = (state == S_WAIT) && !Done &&
                    (wcnt == WW'(WDOG_CYC - 1));

  always_ff @(posedge Clock) begin
    if (Reset || state != S_WAIT) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || start_ok) begin
      fault_q <= 1'b0;
    end else if (wdog_hit) begin
      fault_q <= 1'b1;
    end
  end

  assign Fault = fault_q;
`else
  assign wdog_hit = 1'b0;
  assign Fault    = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_IDLE;
      pc    <= '0;
      len   <= '0;
      op_q  <= OP_MV;
    end else begin
      unique case (state)
        S_IDLE, S_HALT: begin
          if (Start) begin
            len   <= ProgLen;
            pc    <= '0;
            state <= (ProgLen == '0) ? S_HALT : S_ISSUE;
          end
        end
        S_ISSUE: begin
          op_q  <= op_of(cur_w);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (Done) begin
            if (npc >= len) begin
              state <= S_HALT;
            end else begin
              pc    <= npc[AW-1:0];
              state <= S_ISSUE;
            end
          end else if (wdog_hit) begin
            state <= S_HALT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    DIN = '0;
    unique case (state)
      S_ISSUE: DIN = cur_w;
      S_WAIT:  DIN = (op_q == OP_MVI) ? nxt_w : '0;
      default: DIN = '0;
    endcase
  end

  assign Run    = (state == S_ISSUE);
  assign Busy   = (state == S_ISSUE) || (state == S_WAIT);
  assign Halted = (state == S_HALT);
  assign PC     = pc;

endmodule

// File: tb/tb_instr_feeder.sv
// Scoreboard bench for instr_feeder with a behavioural program model.
// A responder process plays the processor's Done handshake.
module tb_instr_feeder;

  localparam int AW = 4;
  localparam int D  = 16;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          LdEn;
  logic [AW-1:0] LdAddr;
  logic [15:0]   LdData;
  logic          Start;
  logic [AW:0]   ProgLen;
  logic [15:0]   DIN;
  logic          Run;
  logic          Done;
  logic [AW-1:0] PC;
  logic          Busy;
  logic          Halted;
  logic          Fault;

  always #5 Clock = ~Clock;

  instr_feeder #(.AW(AW), .WDOG_CYC(15)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .LdEn    (LdEn),
    .LdAddr  (LdAddr),
    .LdData  (LdData),
    .Start   (Start),
    .ProgLen (ProgLen),
    .DIN     (DIN),
    .Run     (Run),
    .Done    (Done),
    .PC      (PC),
    .Busy    (Busy),
    .Halted  (Halted),
    .Fault   (Fault)
  );

  typedef struct {
    int          pc;
    logic [15:0] w;
    logic [15:0] after;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur_e;
  int          run_times[$];
  logic [15:0] shm [D];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_pc = 0;
  bit          hold = 0;
  bit          rnd = 0;
  bit          pend = 0;
  logic [15:0] pend_v;
  int          wcnt = 0;
  int          dly = 0;
  logic [2:0]  rop;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every Run pulse must match the next expected issue.
  always @(negedge Clock) begin
    if (pend) begin
      chk("wait_din", 32'(DIN), 32'(pend_v));
      chk("wait_run", 32'(Run), 32'd0);
      pend = 0;
    end
    if (Run) begin
      run_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_run: pc %0d din %h", PC, DIN);
      end else begin
        cur_e = exp_q.pop_front();
        chk("issue_din", 32'(DIN), 32'(cur_e.w));
        chk("issue_pc", 32'(PC), 32'(cur_e.pc));
        pend   = 1;
        pend_v = cur_e.after;
      end
    end
  end

  // Processor stand-in: mv/mvi take 1 wait cycle, add/sub 3.
  always @(negedge Clock) begin
    if (!hold) begin
      if (Run) begin
        rop  = DIN[8:6];
        dly  = (rop < 3'd2) ? 1 : 3;
        if (rnd) dly += $urandom_range(0, 2);
        wcnt = 0;
        Done = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end else if (Busy) begin
        wcnt++;
        Done = (wcnt == dly);
      end else begin
        Done = 1'b0;
      end
    end
  end

  task automatic model(int len);
    int          p;
    logic [15:0] w;
    logic [2:0]  op;
    exp_t        e;
    p = 0;
    last_pc = 0;
    while (p < len) begin
      w       = shm[p % D];
      op      = w[8:6];
      e.pc    = p;
      e.w     = w;
      e.after = (op == 3'd1) ? shm[(p + 1) % D] : 16'h0;
      exp_q.push_back(e);
      last_pc = p;
      p += (op == 3'd1) ? 2 : 1;
    end
  endtask

  task automatic load(int a, logic [15:0] d, bit upd);
    @(negedge Clock);
    LdEn   = 1'b1;
    LdAddr = AW'(a);
    LdData = d;
    @(negedge Clock);
    LdEn = 1'b0;
    if (upd) shm[a] = d;
  endtask

  task automatic start(int len);
    @(negedge Clock);
    model(len);
    Start   = 1'b1;
    ProgLen = (AW+1)'(len);
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_halt(string name);
    int n;
    n = 0;
    while (!Halted && n < 300) begin
      @(negedge Clock);
      n++;
    end
    chk(name, 32'(Halted), 32'd1);
    chk({name, "_pc"}, 32'(PC), 32'(last_pc));
    chk({name, "_busy"}, 32'(Busy), 32'd0);
    chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1);
  end

  initial begin
    Reset   = 1'b1;
    LdEn    = 1'b0;
    LdAddr  = '0;
    LdData  = '0;
    Start   = 1'b0;
    ProgLen = '0;
    Done    = 1'b0;
    repeat (2) @(negedge Clock);
    chk("rst_run", 32'(Run), 32'd0);
    chk("rst_din", 32'(DIN), 32'd0);
    chk("rst_pc", 32'(PC), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);
    chk("rst_fault", 32'(Fault), 32'd0);
    Reset = 1'b0;
    for (int i = 0; i < D; i++) load(i, 16'h0, 1);

    // mvi with its immediate, then halt at PC 0
    load(0, 16'h0040, 1);
    load(1, 16'h0005, 1);
    start(2);
    wait_halt("t1_halt");

    // mv, add, sub: issue spacing 2 then 4
    load(0, 16'h0000, 1);
    load(1, 16'h0080, 1);
    load(2, 16'h00C0, 1);
    run_times.delete();
    start(3);
    wait_halt("t2_halt");
    chk("t2_runs", 32'(run_times.size()), 32'd3);
    if (run_times.size() == 3) begin
      chk("t2_gap1", 32'(run_times[1] - run_times[0]), 32'd2);
      chk("t2_gap2", 32'(run_times[2] - run_times[1]), 32'd4);
    end

    // zero-length program, then load while halted
    run_times.delete();
    start(0);
    chk("t3_halted", 32'(Halted), 32'd1);
    chk("t3_run", 32'(Run), 32'd0);
    @(negedge Clock);
    chk("t3_no_run", 32'(run_times.size()), 32'd0);
    load(3, 16'hBEEF, 1);
    load(0, 16'h0001, 1);
    load(1, 16'h0081, 1);
    load(2, 16'h0002, 1);
    start(4);
    wait_halt("t3_readback");

    // Start and LdEn during WAIT are ignored
    load(0, 16'h0080, 1);
    hold = 1;
    Done = 1'b0;
    start(1);
    repeat (2) @(negedge Clock);
    Start   = 1'b1;
    ProgLen = 5'd5;
    LdEn    = 1'b1;
    LdAddr  = 4'd0;
    LdData  = 16'hFFFF;
    @(negedge Clock);
    Start = 1'b0;
    LdEn  = 1'b0;
    chk("t4_pc", 32'(PC), 32'd0);
    chk("t4_busy", 32'(Busy), 32'd1);
    repeat (2) @(negedge Clock);
    chk("t4_still_wait", 32'(Busy), 32'd1);
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
    hold = 0;
    wait_halt("t4_halt");
    start(1);
    wait_halt("t4_ram_kept");

    // Reset in the middle of an add
    hold = 1;
    Done = 1'b0;
    start(1);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("t5_run", 32'(Run), 32'd0);
    chk("t5_din", 32'(DIN), 32'd0);
    chk("t5_busy", 32'(Busy), 32'd0);
    chk("t5_halted", 32'(Halted), 32'd0);
    chk("t5_pc", 32'(PC), 32'd0);
    hold = 0;
    start(1);
    wait_halt("t5_ram_kept");

`ifdef INSTR_FEEDER_WDOG_EN
    // illegal opcode never completes; watchdog halts with Fault
    load(0, 16'h0100, 1);
    hold = 1;
    Done = 1'b0;
    start(1);
    @(negedge Clock);
    repeat (14) @(negedge Clock);
    chk("t6_pre_halt", 32'(Halted), 32'd0);
    chk("t6_pre_fault", 32'(Fault), 32'd0);
    @(negedge Clock);
    chk("t6_halted", 32'(Halted), 32'd1);
    chk("t6_fault", 32'(Fault), 32'd1);
    hold = 0;
    load(0, 16'h0000, 1);
    start(1);
    chk("t6_fault_clr", 32'(Fault), 32'd0);
    wait_halt("t6_restart");
`endif

    // mvi as the last word reads its immediate from wrapped address 0
    for (int i = 0; i < D - 1; i++) load(i, 16'(i), 1);
    load(D - 1, 16'h0047, 1);
    start(D);
    wait_halt("wrap_halt");

    // random programs, random Done delays and spurious Done in ISSUE
    rnd = 1;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < D; i++) begin
        logic [15:0] w;
        w      = 16'($urandom);
        w[8:6] = 3'($urandom_range(0, 3));
        load(i, w, 1);
      end
      start($urandom_range(1, D));
      wait_halt("rand_halt");
    end
    rnd = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
